// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: keys an rc4 core, buffers its keystream in a FIFO and XORs it onto a byte stream.
// Define RC4_DROP_EN to discard the first DROP_N keystream bytes after each key load (RC4-drop).
module rc4_stream_xor #(
    parameter int KEY_SIZE   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_N     = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*KEY_SIZE-1:0] key_flat,
    output logic                  gen_rst,
    output logic [7:0]            gen_key,
    input  logic                  gen_ready,
    input  logic [7:0]            gen_k,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_data,
    output logic                  busy,
    output logic                  overflow
);
`ifdef RC4_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
    localparam int DW = (DROP_N > 1) ? $clog2(DROP_N) : 1;

    typedef enum logic [2:0] {IDLE, RST, LOAD, DROP, RUN} state_t;
    state_t state;

    logic [8*KEY_SIZE-1:0] key_r;
    logic [CW-1:0]         cnt, nxt;
    logic [DW-1:0]         dcnt;
    logic [7:0]            mem [FIFO_DEPTH];
    logic [AW:0]           wp, rp;
    logic                  empty, full, push, pop, rekey;

    assign nxt     = cnt + 1'b1;
    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign s_ready = (state == RUN) && !empty && (!m_valid || m_ready);
    assign pop     = s_valid && s_ready;
    assign push    = (state == RUN) && gen_ready;
    assign rekey   = (state == RUN) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gen_rst <= 1'b1;
            gen_key <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            dcnt    <= '0;
            key_r   <= '0;
        end else begin
            case (state)
                IDLE, RUN: if (start) begin
                    state   <= RST;
                    gen_rst <= 1'b1;
                    busy    <= 1'b1;
                    key_r   <= key_flat;
                end
                RST: begin
                    state   <= LOAD;
                    gen_rst <= 1'b0;
                    gen_key <= key_r[7:0];
                    cnt     <= '0;
                end
                LOAD: if (cnt == CW'(KEY_SIZE - 1)) begin
                    gen_key <= '0;
                    dcnt    <= '0;
                    state   <= DROP_EN ? DROP : RUN;
                    busy    <= DROP_EN;
                end else begin
                    gen_key <= key_r[8*nxt +: 8];
                    cnt     <= nxt;
                end
                DROP: if (gen_ready) begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DW'(DROP_N - 1)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A push into a full FIFO is only safe when the head is leaving in the same cycle.
    always_ff @(posedge clk) begin
        if (push && !rekey && (!full || pop)) mem[wp[AW-1:0]] <= gen_k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
        end else if (rekey) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
            m_valid  <= 1'b0;
        end else begin
            if (push && (!full || pop)) wp <= wp + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
            if (pop) begin
                rp      <= rp + 1'b1;
                m_valid <= 1'b1;
                m_data  <= s_data ^ mem[rp[AW-1:0]];
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rc4_stream_xor.sv
// tb_rc4_stream_xor: drives rc4_stream_xor with a behavioural rc4 core and checks the XOR stream
// against an RC4 reference computed from the key.
module tb_rc4_stream_xor;
    localparam int KS = 3;
    localparam int FD = 4;
    localparam int DN = 4;
`ifdef RC4_DROP_EN
    localparam int DROPS = DN;
`else
    localparam int DROPS = 0;
`endif
    localparam logic [23:0] KEY = 24'h79654B;

    typedef logic [7:0] bq_t[$];

    logic        clk, rst_n, start;
    logic [23:0] key_flat;
    logic        gen_rst, gen_ready;
    logic [7:0]  gen_key, gen_k;
    logic        s_valid, s_ready, m_valid, m_ready, busy, overflow;
    logic [7:0]  s_data, m_data;

    int   npass = 0;
    int   ntot  = 0;
    bq_t  out_q;

    rc4_stream_xor #(.KEY_SIZE(KS), .FIFO_DEPTH(FD), .DROP_N(DN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_flat(key_flat),
        .gen_rst(gen_rst), .gen_key(gen_key), .gen_ready(gen_ready), .gen_k(gen_k),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in rc4 core: takes KS key bytes after reset falls, then emits one byte every 2 cycles.
    initial begin : core
        logic [7:0] s [256];
        logic [7:0] kb [KS];
        logic [7:0] t;
        int lc, ci, cj, x;
        bit ph;
        gen_ready <= 1'b0;
        gen_k     <= '0;
        lc = 0; ph = 0; ci = 0; cj = 0;
        forever begin
            @(posedge clk);
            gen_ready <= 1'b0;
            if (gen_rst) begin
                lc = 0;
                ph = 0;
            end else if (lc < KS) begin
                kb[lc] = gen_key;
                lc++;
                if (lc == KS) begin
                    for (int i = 0; i < 256; i++) s[i] = 8'(i);
                    cj = 0;
                    for (int i = 0; i < 256; i++) begin
                        cj = (cj + int'(s[i]) + int'(kb[i % KS])) % 256;
                        t = s[i]; s[i] = s[cj]; s[cj] = t;
                    end
                    ci = 0; cj = 0;
                end
            end else begin
                ph = !ph;
                if (ph) begin
                    ci = (ci + 1) % 256;
                    cj = (cj + int'(s[ci])) % 256;
                    t = s[ci]; s[ci] = s[cj]; s[cj] = t;
                    x = (int'(s[ci]) + int'(s[cj])) % 256;
                    gen_k     <= s[x];
                    gen_ready <= 1'b1;
                end
            end
        end
    end

    function automatic bq_t ref_ks(input logic [23:0] key, input int n);
        int s [256];
        int i = 0, j = 0, t;
        bq_t q;
        for (int k = 0; k < 256; k++) s[k] = k;
        for (int k = 0; k < 256; k++) begin
            j = (j + s[k] + int'(key[8*(k % KS) +: 8])) % 256;
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        j = 0;
        for (int k = 0; k < DROPS + n; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (k >= DROPS) q.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
        return q;
    endfunction

    function automatic bq_t xor_q(input bq_t d, input logic [23:0] key);
        bq_t ks = ref_ks(key, d.size());
        bq_t r;
        foreach (d[i]) r.push_back(d[i] ^ ks[i]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [23:0] key);
        @(negedge clk);
        key_flat = key;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run();
        int c = 0;
        while (busy && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk("run_reached", busy, 0);
    endtask

    task automatic check_load(input logic [23:0] key);
        chk("rst_high", gen_rst, 1);
        for (int i = 0; i < KS; i++) begin
            @(negedge clk);
            chk("load_rst_low", gen_rst, 0);
            chk("load_key", gen_key, key[8*i +: 8]);
            chk("load_busy", busy, 1);
        end
        @(negedge clk);
        chk("key_cleared", gen_key, 0);
        chk("busy_after_load", busy, DROPS > 0);
        wait_run();
    endtask

    task automatic run_stream(input bq_t data, input bq_t exp, input int mode);
        int sent = 0, got = 0, cyc = 0;
        bit stall = 0;
        logic [7:0] hold = '0;
        out_q.delete();
        while (got < data.size() && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hold);
            end
            m_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
            s_valid = sent < data.size();
            s_data  = s_valid ? data[sent] : 8'h00;
            #1;
            if (s_valid && s_ready) sent++;
            if (m_valid && m_ready) begin
                out_q.push_back(m_data);
                chk("m_data", m_data, exp[got]);
                got++;
            end
            stall = m_valid && !m_ready;
            hold  = m_data;
        end
        chk("stream_len", got, data.size());
        chk("no_overflow", overflow, 0);
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    initial begin
        string pt = "Plaintext";
        logic [7:0] sc1 [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        bq_t plain, ct, exp1, rd;
        logic [23:0] rk;
        rst_n = 1'b0; start = 1'b0; key_flat = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        for (int i = 0; i < pt.len(); i++) plain.push_back(pt[i]);
        exp1 = xor_q(plain, KEY);
        repeat (3) @(negedge clk);
        chk("rst_gen_rst", gen_rst, 1);
        chk("rst_gen_key", gen_key, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_gen_rst", gen_rst, 1);
        chk("idle_busy", busy, 0);

        // Known-answer encrypt, then decrypt of the captured ciphertext.
        do_start(KEY);
        check_load(KEY);
        run_stream(plain, exp1, 0);
`ifdef RC4_DROP_EN
        chk("drop_first", out_q[0], 8'hE7);
`else
        for (int i = 0; i < 9; i++) chk("kat_cipher", out_q[i], sc1[i]);
`endif
        ct = out_q;
        do_start(KEY);
        wait_run();
        run_stream(ct, plain, 0);

        // Idle consumer lets the keystream overrun the FIFO.
        do_start(KEY);
        wait_run();
        repeat (2 * FD + 10) @(negedge clk);
        chk("overflow_set", overflow, 1);
        do_start(KEY);
        chk("overflow_cleared", overflow, 0);
        wait_run();
        run_stream(plain, exp1, 0);

        // Downstream stalls every other cycle.
        do_start(KEY);
        wait_run();
        run_stream(plain, exp1, 1);

        // Asynchronous reset in the middle of key load.
        do_start(KEY);
        @(negedge clk);
        chk("mid_load_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gen_rst", gen_rst, 1);
        chk("async_m_valid", m_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_gen_key", gen_key, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(KEY);
        wait_run();
        run_stream(plain, exp1, 0);

        // Random keys and payloads; a stray start during RST must not change the key.
        repeat (6) begin
            rk = 24'($urandom);
            rd.delete();
            repeat ($urandom_range(1, 24)) rd.push_back(8'($urandom));
            do_start(rk);
            key_flat = ~rk;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_run();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_stream(rd, xor_q(rd, rk), int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
